// File: rtl/pc_pila.sv
// pc_pila: program counter with a return-address stack.
// Handles sequential fetch, jumps, calls (push pc+1 and jump) and returns
// (pop into pc). It also keeps sticky overflow/underflow flags for stack misuse.
module pc_pila #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_inc,
   input  logic              s_pila,
   input  logic              push,
   input  logic              pop,
   input  logic [PC_W-1:0]   dir_salto,
   output logic [PC_W-1:0]   pc,
   output logic [PTR_W:0]    sp,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [PC_W-1:0]  mem [DEPTH];
   logic [PC_W-1:0]  pc_plus1;
   logic [PTR_W:0]   sp_minus1;
   logic [PC_W-1:0]  top_entry;
   logic             do_call;
   logic             do_ret;
   logic             call_blocked;
   logic             ret_blocked;
   logic [PC_W-1:0]  pc_next;
   logic [PTR_W:0]   sp_next;

   assign full      = (sp == FULL_COUNT);
   assign empty     = (sp == '0);
   assign pc_plus1  = pc + 1'b1;
   assign sp_minus1 = sp - 1'b1;
   assign top_entry = mem[sp_minus1[PTR_W-1:0]];

   // Decode the stack request. Push and pop only count when s_pila is set,
   // and only when exactly one of them is asserted.
   always_comb begin
      do_call      = 1'b0;
      do_ret       = 1'b0;
      call_blocked = 1'b0;
      ret_blocked  = 1'b0;
      if (s_pila) begin
         if (push && !pop) begin
            do_call      = !full;
            call_blocked = full;
         end else if (pop && !push) begin
            do_ret       = !empty;
            ret_blocked  = empty;
         end
      end
   end

   // Select the next pc and stack pointer. Every stack-mode cycle that is not
   // a successful call or return simply advances pc by one.
   always_comb begin
      pc_next = pc_plus1;
      sp_next = sp;
      if (!s_pila) begin
         pc_next = s_inc ? pc_plus1 : dir_salto;
      end else if (do_call) begin
         pc_next = dir_salto;
         sp_next = sp + 1'b1;
      end else if (do_ret) begin
         pc_next = top_entry;
         sp_next = sp_minus1;
      end
   end

   // Register pc, sp and the sticky error flags. Reset takes effect at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= '0;
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pc <= pc_next;
         sp <= sp_next;
         if (call_blocked) overflow  <= 1'b1;
         if (ret_blocked)  underflow <= 1'b1;
      end
   end

   // Write the return address into the stack. The array is left unreset.
   always_ff @(posedge clk) begin
      if (do_call && !reset) begin
         mem[sp[PTR_W-1:0]] <= pc_plus1;
      end
   end

endmodule

// File: tb/tb_pc_pila.sv
// tb_pc_pila: directed self-checking bench for pc_pila using hand-computed values.
module tb_pc_pila;

   logic        clk;
   logic        reset;
   logic        s_inc;
   logic        s_pila;
   logic        push;
   logic        pop;
   logic [9:0]  dir_salto;
   logic [9:0]  pc;
   logic [4:0]  sp;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        underflow;

   int errors = 0;
   int checks = 0;

   pc_pila #(.PC_W(10), .DEPTH(16), .PTR_W(4)) dut (
      .clk(clk), .reset(reset), .s_inc(s_inc), .s_pila(s_pila),
      .push(push), .pop(pop), .dir_salto(dir_salto), .pc(pc), .sp(sp),
      .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and count the check.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then let one rising edge
   // pass. The task returns at the next falling edge so outputs can be sampled.
   task automatic applyStimulus(input logic inc, input logic pila, input logic ps,
                                input logic pp, input logic [9:0] dir);
      s_inc     = inc;
      s_pila    = pila;
      push      = ps;
      pop       = pp;
      dir_salto = dir;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run the directed scenarios in sequence.
   initial begin
      logic [9:0] exp_pc;
      reset = 1'b1; s_inc = 1'b1; s_pila = 1'b0; push = 1'b0; pop = 1'b0;
      dir_salto = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_pc", 16'(pc), 16'h0);
      checkOutput("reset_sp", 16'(sp), 16'h0);
      checkOutput("reset_empty", 16'(empty), 16'h1);
      checkOutput("reset_full", 16'(full), 16'h0);
      checkOutput("reset_flags", 16'({overflow, underflow}), 16'h0);
      reset = 1'b0;

      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
         checkOutput("inc_pc", 16'(pc), 16'(i));
      end
      checkOutput("inc_sp", 16'(sp), 16'h0);
      checkOutput("inc_empty", 16'(empty), 16'h1);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h2A0);
      checkOutput("jump_pc", 16'(pc), 16'h2A0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
      checkOutput("jump_inc_pc", 16'(pc), 16'h2A1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF);
      checkOutput("jump_max_pc", 16'(pc), 16'h3FF);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
      checkOutput("wrap_pc", 16'(pc), 16'h000);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h010);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'h100);
      checkOutput("call_pc", 16'(pc), 16'h100);
      checkOutput("call_sp", 16'(sp), 16'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
      checkOutput("body_pc", 16'(pc), 16'h102);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 10'h0);
      checkOutput("ret_pc", 16'(pc), 16'h011);
      checkOutput("ret_sp", 16'(sp), 16'h0);
      checkOutput("ret_empty", 16'(empty), 16'h1);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'(10'h200 + i * 4));
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'(10'h300 + i));
         checkOutput("nest_call_pc", 16'(pc), 16'(10'h300 + i));
         checkOutput("nest_call_sp", 16'(sp), 16'(i + 1));
      end
      checkOutput("nest_full", 16'(full), 16'h1);
      checkOutput("nest_no_ovf", 16'(overflow), 16'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h050);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'h111);
      checkOutput("ovf_pc", 16'(pc), 16'h051);
      checkOutput("ovf_sp", 16'(sp), 16'h10);
      checkOutput("ovf_flag", 16'(overflow), 16'h1);
      for (int k = 0; k < 16; k++) begin
         exp_pc = 10'(10'h200 + (15 - k) * 4 + 1);
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 10'h0);
         checkOutput("lifo_pc", 16'(pc), 16'(exp_pc));
         checkOutput("lifo_sp", 16'(sp), 16'(15 - k));
      end
      checkOutput("lifo_empty", 16'(empty), 16'h1);
      checkOutput("ovf_sticky", 16'(overflow), 16'h1);
      checkOutput("no_udf_yet", 16'(underflow), 16'h0);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h020);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 10'h0);
      checkOutput("udf_pc", 16'(pc), 16'h021);
      checkOutput("udf_sp", 16'(sp), 16'h0);
      checkOutput("udf_flag", 16'(underflow), 16'h1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h3C0);
      checkOutput("both_pc", 16'(pc), 16'h022);
      checkOutput("both_sp", 16'(sp), 16'h0);
      checkOutput("both_flags", 16'({overflow, underflow}), 16'h3);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h3C0);
      checkOutput("stale_push_pc", 16'(pc), 16'h023);
      checkOutput("stale_push_sp", 16'(sp), 16'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h3C0);
      checkOutput("idle_stack_pc", 16'(pc), 16'h024);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h010);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'h020);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'h030);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'h123);
      checkOutput("pre_rst_pc", 16'(pc), 16'h123);
      checkOutput("pre_rst_sp", 16'(sp), 16'h3);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_pc", 16'(pc), 16'h0);
      checkOutput("async_rst_sp", 16'(sp), 16'h0);
      checkOutput("async_rst_flags", 16'({overflow, underflow}), 16'h0);
      checkOutput("async_rst_empty", 16'(empty), 16'h1);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
      checkOutput("post_rst_pc", 16'(pc), 16'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_pila.md
Name: pc_pila

Overview:
- Program-counter and return-address stack stage, directly downstream of the control unit.
- Consumes the next-PC select (s_inc), the stack select (s_pila) and the push/pop strobes, plus the jump target field from the instruction.
- Produces the instruction-memory address (pc) and the stack status flags.
- Implements jump, conditional-jump resolution (already decided upstream via s_inc), call (push) and return (pop).

Parameters:
- PC_W, 10, width of program counter and jump target.
- DEPTH, 16, number of return-address entries; must be a power of 2, minimum 2.
- PTR_W, 4, log2(DEPTH); sp output is PTR_W+1 bits wide.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_inc  input  1  1: next pc = pc+1; 0: next pc = dir_salto (used only when s_pila=0).
- s_pila  input  1  1: stack operation this cycle; push/pop qualified by it.
- push  input  1  call request (valid only with s_pila=1).
- pop  input  1  return request (valid only with s_pila=1).
- dir_salto  input  PC_W  jump/call target from instruction field.
- pc  output  PC_W  current program counter (registered).
- sp  output  PTR_W+1  number of valid stack entries, 0..DEPTH (registered).
- full  output  1  sp == DEPTH (combinational from sp).
- empty  output  1  sp == 0 (combinational from sp).
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, immediate): pc=0, sp=0, overflow=0, underflow=0; hence full=0, empty=1. Stack RAM contents are not reset.
- Next-state decision per rising edge, priority in this order:
  1. s_pila=0: pc <= s_inc ? pc+1 : dir_salto; stack untouched; push/pop ignored.
  2. s_pila=1, push=1, pop=0, not full (call): mem[sp] <= pc+1; sp <= sp+1; pc <= dir_salto.
  3. s_pila=1, push=1, pop=0, full: overflow <= 1; sp and mem unchanged; pc <= pc+1 (call suppressed).
  4. s_pila=1, pop=1, push=0, not empty (return): pc <= mem[sp-1]; sp <= sp-1.
  5. s_pila=1, pop=1, push=0, empty: underflow <= 1; sp unchanged; pc <= pc+1.
  6. s_pila=1, push=pop (both 0 or both 1): no stack change, no flag change; pc <= pc+1.
- Latency: every pc update takes effect one cycle after the edge on which the inputs are sampled; a return uses the entry written by a call on any earlier edge (no same-cycle bypass needed, since push and pop are exclusive).
- Arithmetic: pc+1 wraps modulo 2^PC_W (max value -> 0). Pushed value is also computed modulo 2^PC_W.
- overflow/underflow are sticky and are cleared only by reset.
- Storage: stack is a DEPTH x PC_W register array indexed by sp[PTR_W-1:0]; read is combinational from the array.
- Reset mid-operation: reset asserted on any cycle aborts the pending update; the next state is the reset state regardless of inputs.
- X-safety: push/pop may hold stale values while s_pila=0; the block must not act on them.

Test Plan:
- Reset then s_pila=0, s_inc=1 for 5 cycles -> pc 0,1,2,3,4,5; sp=0, empty=1.
- At pc=5, s_inc=0, dir_salto=0x2A0 -> next pc=0x2A0; then s_inc=1 -> 0x2A1. With pc=0x3FF, s_inc=1 -> pc=0x000.
- Call/return: at pc=0x010, s_pila=1, push=1, dir_salto=0x100 -> pc=0x100, sp=1. Two cycles of increment (pc=0x102), then s_pila=1, pop=1 -> pc=0x011, sp=0, empty=1.
- Nested calls: DEPTH=16, 16 calls from distinct pcs -> sp=16, full=1. 17th call at pc=0x050 -> overflow=1, sp=16, pc=0x051. 16 returns -> addresses come back in LIFO order, sp=0; overflow still 1.
- Underflow and illegal combinations: pop with sp=0 at pc=0x020 -> underflow=1, pc=0x021, sp=0. s_pila=1 with push=pop=1 -> pc+1, sp and flags unchanged.
- Async reset mid-call: sp=3, pc=0x123, assert reset between edges -> pc=0, sp=0, flags 0 immediately, without waiting for a clock edge. Deassert, then s_inc=1 -> pc=1.
